pipe_event_monitor: RTL
=======================

# pipe_event_monitor

Synthesizable, parametrised performance monitor for the pipelined CPU. It counts run cycles and up to `NUM_EVT` single-bit pipeline events, such as HDU stall (`nope_o` with `PC_ctrl_o == 2'b00`) and HDU flush (`Flush_o`). Counting is gated by a run window that opens on `start_i` and closes on `stop_i` or after `MAX_CYCLES` cycles. Software or the bench reads counters through a one-deep request/acknowledge port, which replaces hierarchical peeking at stall/flush integers.

## Interface
- `NUM_EVT`, 2: number of event channels.
- `CNT_W`, 32: width of every counter, cycle counter included.
- `MAX_CYCLES`, 30: run-window length in cycles; 0 = unlimited.
- `SEL_W`, $clog2(NUM_EVT+1): derived, not overridable.

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  open run window (level, sampled in IDLE)
- `stop_i`  in  1  close run window early
- `clear_i`  in  1  zero all counters/flags, return to IDLE
- `evt_i`  in  NUM_EVT  event strobes, bit k → counter k+1
- `rd_req_i`  in  1  read request
- `rd_sel_i`  in  SEL_W  0 = cycle counter, k = event k-1
- `rd_ack_o`  out  1  read data valid, one-cycle pulse
- `rd_data_o`  out  CNT_W  read data
- `ovf_o`  out  NUM_EVT+1  sticky saturation flags, bit = counter index
- `running_o`  out  1  state == RUN
- `done_o`  out  1  state == DONE

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when `start_i` = 1.
  - RUN → DONE when `stop_i` = 1, or when `MAX_CYCLES` ≠ 0 and this cycle's increment makes the cycle counter equal `MAX_CYCLES`.
  - DONE → IDLE only on `clear_i`. `start_i` is ignored in RUN and DONE.
- `clear_i` has priority over everything in any state:
  - next state IDLE;
  - all counters and `ovf_o` go to 0;
  - a read requested in the same cycle returns the pre-clear value.
- In RUN, each cycle:
  - the cycle counter increments by 1;
  - counter k+1 increments when `evt_i[k]` = 1;
  - all increments for a cycle happen in parallel.
- The cycle in which `stop_i` is seen is still counted, including its events. IDLE and DONE cycles are never counted.
- Saturation: a counter at 2^CNT_W−1 stays there. Its `ovf_o` bit sets on the first attempted increment beyond that value and stays set until `clear_i` or reset.
- Read port:
  - A request is accepted when `rd_req_i` = 1 and `rd_ack_o` = 0.
  - The selected counter is sampled at the accepting edge, so the value excludes that cycle's increment.
  - `rd_sel_i` > NUM_EVT returns 0.
  - Holding `rd_req_i` high yields an ack every other cycle.
- Reset values: state IDLE, all counters 0, `ovf_o` 0, `rd_ack_o` 0, `rd_data_o` 0, `running_o` 0, `done_o` 0.
- Reset asserted mid-run aborts immediately and asynchronously to the reset values. A pending ack is dropped.

## Timing
- `start_i` high at edge n → `running_o` high after edge n. The first counted cycle is cycle n+1.
- With `MAX_CYCLES` = M, exactly M cycles are counted. `done_o` rises after the edge that brings the cycle counter to M.
- Read latency is 1 cycle: accepted at edge n → `rd_ack_o` and `rd_data_o` valid in the cycle after edge n. `rd_data_o` holds until the next ack.
- `running_o`, `done_o`, and `ovf_o` are registered outputs; there is no combinational input-to-output path.

## Structure
- The shared package `mips_pkg` holds:
  - the FSM state enum `mon_state_t` (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - the event index constants `EVT_STALL` = 0 and `EVT_FLUSH` = 1, used by the CPU top to build `evt_i`.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `rst`, `clr`, `inc`, `cnt`, `ovf`) is instantiated NUM_EVT+1 times. The top level contains the FSM, the read mux and the ack register.

## Test plan
- Reset, then `start_i` for one cycle with `evt_i` = 0 and M = 30 → `done_o` rises exactly 30 cycles after `running_o`. Reading sel 0 then returns 30, and sel 1 and sel 2 return 0.
- In RUN, drive `evt_i` = 2'b01 for 3 cycles, 2'b11 for 2 cycles, 2'b10 for 1 cycle, then `stop_i` alongside `evt_i` = 2'b10 → reads return sel 1 = 5, sel 2 = 4, sel 0 = 7. The FSM stays in DONE while `start_i` is pulsed.
- With `CNT_W` = 4 and `MAX_CYCLES` = 0, hold `evt_i[0]` for 20 run cycles → counter 1 reads 15 and `ovf_o[1]` = 1. `ovf_o[0]` sets on cycle 16.
- `rd_req_i` with sel 1 in the same cycle as an `evt_i[0]` increment from 6 → `rd_data_o` = 6 on the ack. A follow-up read returns 7.
- Assert `clear_i` together with `start_i` and a read of sel 0 = 12 → the ack returns 12; afterwards the FSM is IDLE with all counters 0.
- Drop `rst` low mid-RUN between clock edges → all outputs are 0 immediately. After release, `start_i` restarts counting from 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared CPU-side definitions: monitor FSM encoding and the event channel
// assignments the CPU top uses to build the monitor's evt_i vector.
package mips_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } mon_state_t;

  localparam int unsigned EVT_STALL = 0;
  localparam int unsigned EVT_FLUSH = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky overflow flag that sets on the first
// increment attempted while the count is already at its maximum.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         ovf
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/pipe_event_monitor.sv
// Pipeline performance monitor: run-window FSM, one saturating counter per
// event plus a cycle counter, and a one-deep request/acknowledge read port.
module pipe_event_monitor
  import mips_pkg::*;
#(
  parameter int unsigned  NUM_EVT    = 2,
  parameter int unsigned  CNT_W      = 32,
  parameter int unsigned  MAX_CYCLES = 30,
  localparam int unsigned SEL_W      = $clog2(NUM_EVT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               clear_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               rd_req_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic               rd_ack_o,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic               running_o,
  output logic               done_o
);

  mon_state_t state_q;
  logic       running_q, done_q;

  logic [CNT_W-1:0] cnt_all [NUM_EVT+1];
  logic [NUM_EVT:0] inc;
  logic [CNT_W:0]   cyc_next;
  logic             max_hit;

  // Counter 0 is the cycle counter; counter k+1 tracks evt_i[k].
  always_comb begin
    inc    = '0;
    inc[0] = (state_q == StRun);
    for (int unsigned k = 0; k < NUM_EVT; k++) begin
      inc[k+1] = (state_q == StRun) && evt_i[k];
    end
  end

  for (genvar g = 0; g <= NUM_EVT; g++) begin : gen_cnt
    sat_counter #(
      .W(CNT_W)
    ) u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(clear_i),
      .inc(inc[g]),
      .cnt(cnt_all[g]),
      .ovf(ovf_o[g])
    );
  end

  // Widened so a saturated cycle counter cannot alias onto MAX_CYCLES.
  assign cyc_next = {1'b0, cnt_all[0]} + (CNT_W + 1)'(1);
  assign max_hit  = (MAX_CYCLES != 0) && (cyc_next == (CNT_W + 1)'(MAX_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (clear_i) begin
      state_q   <= StIdle;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (stop_i || max_hit) begin
            state_q   <= StDone;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StDone;
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign running_o = running_q;
  assign done_o    = done_q;

  logic             rd_accept;
  logic [CNT_W-1:0] rd_mux;
  logic             rd_ack_q, rd_ack_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i <= NUM_EVT; i++) begin
      if (rd_sel_i == SEL_W'(i)) begin
        rd_mux = cnt_all[i];
      end
    end
  end

  assign rd_accept = rd_req_i && !rd_ack_q;

  always_comb begin
    rd_ack_d  = rd_accept;
    rd_data_d = rd_accept ? rd_mux : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_ack_o  = rd_ack_q;
  assign rd_data_o = rd_data_q;

endmodule
